// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dram_arb_pkg
//  Purpose : Shared definitions for the fixed-slot DRAM arbiter: owner
//            encoding, video density codes, slot geometry, bus widths and
//            the video "due" decision used at every slot boundary.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package dram_arb_pkg;

  // Slot owner, registered at the end of every slot for the next one.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_REF  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  // Video density: how many slots of the fetch window go to video.
  localparam logic [1:0] VDENS_NONE = 2'b00;  // never
  localparam logic [1:0] VDENS_Q    = 2'b01;  // one slot in 4
  localparam logic [1:0] VDENS_H    = 2'b10;  // one slot in 2
  localparam logic [1:0] VDENS_F    = 2'b11;  // every slot

  // Slot geometry.
  localparam int SLOT_LEN = 4;
  localparam int PHASE_W  = $clog2(SLOT_LEN);
  localparam logic [PHASE_W-1:0] PHASE_FIRST = '0;
  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(SLOT_LEN - 1);

  // Bus widths.
  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;
  localparam int BSEL_W = 2;

  // Video is due in a slot when the window is open and the slot index
  // within the 4-slot video cycle matches the selected density.
  function automatic logic video_due(input logic       win,
                                     input logic [1:0] dens,
                                     input logic [1:0] slot);
    logic due;
    due = 1'b0;
    case (dens)
      VDENS_F:    due = 1'b1;
      VDENS_H:    due = ~slot[0];
      VDENS_Q:    due = (slot == 2'b00);
      VDENS_NONE: due = 1'b0;
    endcase
    return win & due;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module  : dram_refresh_timer
//  Purpose : Free-running refresh interval counter with a single pending
//            refresh request flag.
//  Ports   : clk       in   clock
//            rst       in   synchronous active-high reset
//            ref_ack   in   refresh slot granted this clock, clears request
//            ref_pend  out  refresh request pending
//  Params  : REF_INTERVAL  clocks between refresh requests (8..4095)
//  Revision: 1.0  initial release
// ============================================================================
module dram_refresh_timer #(
  parameter int REF_INTERVAL = 440
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_ack,
  output logic ref_pend
);

  localparam int CTR_W = 12;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(REF_INTERVAL - 1);

  logic [CTR_W-1:0] refctr;
  logic             expire;

  assign expire = (refctr == CTR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      refctr   <= '0;
      ref_pend <= 1'b0;
    end else begin
      refctr <= expire ? '0 : refctr + 1'b1;
      // A fresh expiry outranks a simultaneous grant: that grant served the
      // previous interval, so the new interval still needs its own refresh.
      // A second expiry while already pending is simply absorbed.
      if (expire)
        ref_pend <= 1'b1;
      else if (ref_ack)
        ref_pend <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_slot_arb.sv
`default_nettype none
// ============================================================================
//  Module  : dram_slot_arb
//  Purpose : Fixed 4-clock slot DRAM arbiter between video fetch, refresh
//            and CPU (priority video > refresh > CPU > idle). The owner of
//            the next slot is decided in the last clock of the current one.
//  Ports   : clk, rst                      clock, sync active-high reset
//            vfetch_win, vdens, video_addr video fetch window/density/address
//            video_next, video_strobe      video address taken / data valid
//            cpu_req, cpu_rnw, cpu_addr,
//            cpu_wrdata, cpu_bsel          CPU request and payload
//            cpu_next, cpu_strobe          CPU accepted / read data valid
//            dram_req, dram_rnw, dram_addr,
//            dram_wrdata, dram_bsel        access slot to the DRAM controller
//            dram_refresh                  refresh slot to the DRAM controller
//  Params  : REF_INTERVAL  clocks between refresh requests (8..4095)
//  Revision: 1.0  initial release
// ============================================================================
module dram_slot_arb
  import dram_arb_pkg::*;
#(
  parameter int REF_INTERVAL = 440
) (
  input  logic              clk,
  input  logic              rst,
  // video fetch side
  input  logic              vfetch_win,
  input  logic [1:0]        vdens,
  input  logic [ADDR_W-1:0] video_addr,
  output logic              video_next,
  output logic              video_strobe,
  // CPU side
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wrdata,
  input  logic [BSEL_W-1:0] cpu_bsel,
  output logic              cpu_next,
  output logic              cpu_strobe,
  // DRAM controller side
  output logic              dram_req,
  output logic              dram_rnw,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wrdata,
  output logic [BSEL_W-1:0] dram_bsel,
  output logic              dram_refresh
);

  logic [PHASE_W-1:0] phase;
  logic               slot_end;
  owner_t             owner;
  owner_t             owner_nxt;

  logic [1:0]         vslot;
  logic [1:0]         vslot_eff;
  logic               win_prev;
  logic               win_rise;
  logic               vid_due;

  logic               ref_pend;
  logic               ref_ack;

  // --------------------------------------------------------------------------
  // Refresh request source
  // --------------------------------------------------------------------------
  dram_refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_refresh_timer (
    .clk      (clk),
    .rst      (rst),
    .ref_ack  (ref_ack),
    .ref_pend (ref_pend)
  );

  // --------------------------------------------------------------------------
  // Slot phase and video slot counter
  // --------------------------------------------------------------------------
  assign slot_end = (phase == PHASE_LAST);

  // The first decision of a new window starts the video cycle at slot 0 so
  // that the opening slot of every line is always fetched.
  assign win_rise  = vfetch_win & ~win_prev;
  assign vslot_eff = win_rise ? 2'b00 : vslot;
  assign vid_due   = video_due(vfetch_win, vdens, vslot_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PHASE_FIRST;
      vslot    <= 2'b00;
      win_prev <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      if (slot_end) begin
        win_prev <= vfetch_win;
        if (vfetch_win)
          vslot <= vslot_eff + 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Owner FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      owner <= OWN_IDLE;
    else
      owner <= owner_nxt;
  end

  // --------------------------------------------------------------------------
  // Owner FSM: next-state logic (only changes at the slot boundary, so a
  // granted slot always runs to completion)
  // --------------------------------------------------------------------------
  always_comb begin
    owner_nxt = owner;
    if (slot_end) begin
      if (vid_due)
        owner_nxt = OWN_VID;
      else if (ref_pend)
        owner_nxt = OWN_REF;
      else if (cpu_req)
        owner_nxt = OWN_CPU;
      else
        owner_nxt = OWN_IDLE;
    end
  end

  assign ref_ack = slot_end & (owner_nxt == OWN_REF);

  // --------------------------------------------------------------------------
  // Access payload, captured at the decision and held for the whole slot.
  // Refresh and idle slots keep the previous payload on the bus.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dram_rnw    <= 1'b0;
      dram_addr   <= '0;
      dram_wrdata <= '0;
      dram_bsel   <= '0;
    end else if (slot_end) begin
      case (owner_nxt)
        OWN_VID: begin
          dram_rnw  <= 1'b1;
          dram_addr <= video_addr;
          dram_bsel <= 2'b11;
        end
        OWN_CPU: begin
          dram_rnw    <= cpu_rnw;
          dram_addr   <= cpu_addr;
          dram_wrdata <= cpu_wrdata;
          dram_bsel   <= cpu_bsel;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Owner FSM: output logic. Everything is decoded from registered state,
  // so a reset clears all strobes on the following clock.
  // --------------------------------------------------------------------------
  always_comb begin
    dram_req     = 1'b0;
    dram_refresh = 1'b0;
    video_next   = 1'b0;
    video_strobe = 1'b0;
    cpu_next     = 1'b0;
    cpu_strobe   = 1'b0;
    case (owner)
      OWN_VID: begin
        dram_req     = 1'b1;
        video_next   = (phase == PHASE_FIRST);
        video_strobe = slot_end;
      end
      OWN_CPU: begin
        dram_req   = 1'b1;
        cpu_next   = (phase == PHASE_FIRST);
        cpu_strobe = slot_end & dram_rnw;
      end
      OWN_REF: begin
        dram_refresh = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_slot_arb.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dram_slot_arb
//  Purpose : Directed self-checking bench for dram_slot_arb. A second
//            instance with a short refresh interval shares the inputs.
//  Revision: 1.0  initial release
// ============================================================================
module tb_dram_slot_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vfetch_win = 1'b0;
  logic [1:0]  vdens = 2'b00;
  logic [20:0] video_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic [15:0] cpu_wrdata = '0;
  logic [1:0]  cpu_bsel = '0;

  logic        video_next, video_strobe, cpu_next, cpu_strobe;
  logic        dram_req, dram_rnw, dram_refresh;
  logic [20:0] dram_addr;
  logic [15:0] dram_wrdata;
  logic [1:0]  dram_bsel;

  logic        video_next_8, video_strobe_8, cpu_next_8, cpu_strobe_8;
  logic        dram_req_8, dram_rnw_8, dram_refresh_8;
  logic [20:0] dram_addr_8;
  logic [15:0] dram_wrdata_8;
  logic [1:0]  dram_bsel_8;

  logic [45:0] all_out;
  assign all_out = {video_next, video_strobe, cpu_next, cpu_strobe, dram_req,
                    dram_rnw, dram_addr, dram_wrdata, dram_bsel, dram_refresh};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #18 clk = ~clk;

  dram_slot_arb #(.REF_INTERVAL(440)) dut (
    .clk(clk), .rst(rst),
    .vfetch_win(vfetch_win), .vdens(vdens), .video_addr(video_addr),
    .video_next(video_next), .video_strobe(video_strobe),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrdata(cpu_wrdata), .cpu_bsel(cpu_bsel),
    .cpu_next(cpu_next), .cpu_strobe(cpu_strobe),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel), .dram_refresh(dram_refresh)
  );

  dram_slot_arb #(.REF_INTERVAL(8)) dut8 (
    .clk(clk), .rst(rst),
    .vfetch_win(vfetch_win), .vdens(vdens), .video_addr(video_addr),
    .video_next(video_next_8), .video_strobe(video_strobe_8),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrdata(cpu_wrdata), .cpu_bsel(cpu_bsel),
    .cpu_next(cpu_next_8), .cpu_strobe(cpu_strobe_8),
    .dram_req(dram_req_8), .dram_rnw(dram_rnw_8), .dram_addr(dram_addr_8),
    .dram_wrdata(dram_wrdata_8), .dram_bsel(dram_bsel_8), .dram_refresh(dram_refresh_8)
  );

  // Advance to the next sampling point (negedge); cyc is the clock number
  // counted from reset release (clock 0 = first clock with rst low).
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    vfetch_win = 1'b0;
    vdens      = 2'b00;
    video_addr = '0;
    cpu_req    = 1'b0;
    cpu_rnw    = 1'b0;
    cpu_addr   = '0;
    cpu_wrdata = '0;
    cpu_bsel   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    int first_ref;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0)
      $display("FAIL reset_hold: outputs=%h required=0", all_out);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 4) begin
      checks++;
      if (all_out !== '0)
        $display("FAIL idle_after_reset clk%0d: outputs=%h required=0", cyc, all_out);
      step();
    end
    first_ref = -1;
    while (cyc < 500 && first_ref < 0) begin
      if (dram_refresh === 1'b1) first_ref = cyc;
      else step();
    end
    checks++;
    if (first_ref != 444) begin
      errors++;
      $display("FAIL first_refresh_clock: got %0d required 444", first_ref);
    end
    if (first_ref == 444) begin
      repeat (3) begin
        step();
        checks++;
        if (dram_refresh !== 1'b1 || dram_req !== 1'b0) begin
          errors++;
          $display("FAIL refresh_slot_len clk%0d: refresh=%b req=%b required 1/0",
                   cyc, dram_refresh, dram_req);
        end
      end
      step();
      checks++;
      if (dram_refresh !== 1'b0) begin
        errors++;
        $display("FAIL refresh_end clk%0d: refresh=%b required 0", cyc, dram_refresh);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_video();
    int nexts;
    int k;
    int p;
    logic [20:0] exp_addr;
    do_reset();
    vfetch_win = 1'b1;
    vdens      = 2'b11;
    video_addr = 21'h10000;
    nexts = 0;
    while (cyc < 264) begin
      p = cyc % 4;
      k = cyc / 4 - 1;
      if (cyc >= 4 && cyc < 260) begin
        checks++;
        if (video_next !== (p == 0) || video_strobe !== (p == 3)) begin
          errors++;
          $display("FAIL full_video_pulses clk%0d: next=%b strobe=%b required %b/%b",
                   cyc, video_next, video_strobe, (p == 0), (p == 3));
        end
        exp_addr = 21'h10000 + 21'(k);
        checks++;
        if (dram_req !== 1'b1 || dram_refresh !== 1'b0 || cpu_next !== 1'b0 ||
            dram_addr !== exp_addr || dram_rnw !== 1'b1 || dram_bsel !== 2'b11) begin
          errors++;
          $display("FAIL full_video_bus clk%0d: req=%b ref=%b addr=%h rnw=%b bsel=%b required 1/0/%h/1/11",
                   cyc, dram_req, dram_refresh, dram_addr, dram_rnw, dram_bsel, exp_addr);
        end
      end else if (cyc >= 260) begin
        checks++;
        if (dram_req !== 1'b0 || video_next !== 1'b0) begin
          errors++;
          $display("FAIL full_video_closed clk%0d: req=%b next=%b required 0/0",
                   cyc, dram_req, video_next);
        end
      end
      if (video_next === 1'b1) begin
        nexts++;
        video_addr = video_addr + 21'd1;
      end
      if (cyc == 256) vfetch_win = 1'b0;
      step();
    end
    checks++;
    if (nexts != 64) begin
      errors++;
      $display("FAIL full_video_count: got %0d video_next required 64", nexts);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_density_q_cpu();
    int k;
    int p;
    logic vid;
    logic wr;
    logic [20:0] exp_addr;
    logic [15:0] exp_wd;
    logic [1:0]  exp_bsel;
    do_reset();
    vfetch_win = 1'b1;
    vdens      = 2'b01;
    video_addr = 21'h00100;
    cpu_req    = 1'b1;
    cpu_rnw    = 1'b1;
    cpu_addr   = 21'h1ABCD;
    cpu_wrdata = 16'h1234;
    cpu_bsel   = 2'b01;
    while (cyc < 52) begin
      p   = cyc % 4;
      k   = cyc / 4 - 1;
      vid = (k % 4 == 0);
      wr  = (k >= 9) && !vid;
      exp_addr = vid ? 21'h00100 : (wr ? 21'h00055 : 21'h1ABCD);
      exp_bsel = vid ? 2'b11 : (wr ? 2'b10 : 2'b01);
      exp_wd   = wr ? 16'hBEEF : 16'h1234;
      if (cyc >= 4) begin
        if (p == 0) begin
          checks++;
          if (video_next !== vid || cpu_next !== !vid || dram_req !== 1'b1) begin
            errors++;
            $display("FAIL dens_q_owner slot%0d: vnext=%b cnext=%b req=%b required %b/%b/1",
                     k, video_next, cpu_next, dram_req, vid, !vid);
          end
          checks++;
          if (dram_addr !== exp_addr || dram_rnw !== (vid | !wr) || dram_bsel !== exp_bsel ||
              (!vid && dram_wrdata !== exp_wd)) begin
            errors++;
            $display("FAIL dens_q_payload slot%0d: addr=%h rnw=%b bsel=%b wd=%h required %h/%b/%b/%h",
                     k, dram_addr, dram_rnw, dram_bsel, dram_wrdata,
                     exp_addr, (vid | !wr), exp_bsel, exp_wd);
          end
        end else if (p == 3) begin
          checks++;
          if (video_strobe !== vid || cpu_strobe !== (!vid && !wr)) begin
            errors++;
            $display("FAIL dens_q_strobe slot%0d: vstb=%b cstb=%b required %b/%b",
                     k, video_strobe, cpu_strobe, vid, (!vid && !wr));
          end
        end else begin
          checks++;
          if ({video_next, cpu_next, video_strobe, cpu_strobe} !== 4'b0000) begin
            errors++;
            $display("FAIL dens_q_quiet clk%0d: pulses=%b required 0000", cyc,
                     {video_next, cpu_next, video_strobe, cpu_strobe});
          end
        end
      end
      if (cyc == 32) begin
        cpu_rnw    = 1'b0;
        cpu_addr   = 21'h00055;
        cpu_wrdata = 16'hBEEF;
        cpu_bsel   = 2'b10;
      end
      step();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_refresh_vs_cpu();
    int k;
    int p;
    logic exp_ref;
    do_reset();
    cpu_req  = 1'b1;
    cpu_rnw  = 1'b1;
    cpu_addr = 21'h00A0A;
    while (cyc < 52) begin
      p = cyc % 4;
      k = cyc / 4 - 1;
      exp_ref = (k >= 2) && (k % 2 == 0);
      if (cyc >= 4 && p == 0) begin
        checks++;
        if (dram_refresh_8 !== exp_ref || cpu_next_8 !== !exp_ref || dram_req_8 !== !exp_ref) begin
          errors++;
          $display("FAIL ref_vs_cpu slot%0d: ref=%b cnext=%b req=%b required %b/%b/%b",
                   k, dram_refresh_8, cpu_next_8, dram_req_8, exp_ref, !exp_ref, !exp_ref);
        end
        checks++;
        if (cpu_next !== 1'b1 || dram_refresh !== 1'b0) begin
          errors++;
          $display("FAIL long_interval_cpu slot%0d: cnext=%b ref=%b required 1/0",
                   k, cpu_next, dram_refresh);
        end
      end
      if (cyc >= 4 && p == 3) begin
        checks++;
        if (cpu_strobe_8 !== !exp_ref) begin
          errors++;
          $display("FAIL ref_vs_cpu_strobe slot%0d: cstb=%b required %b", k, cpu_strobe_8, !exp_ref);
        end
      end
      step();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_window_edge();
    int k;
    int p;
    logic exp_vid;
    logic exp_ref;
    // Half density: video on the first slot of the window, then every other.
    do_reset();
    vfetch_win = 1'b1;
    vdens      = 2'b10;
    while (cyc < 60) begin
      p = cyc % 4;
      k = cyc / 4 - 1;
      exp_vid = (k < 8) && (k % 2 == 0);
      if (cyc >= 4 && p == 0) begin
        checks++;
        if (video_next !== exp_vid || dram_req !== exp_vid || dram_refresh !== 1'b0) begin
          errors++;
          $display("FAIL window_half slot%0d: vnext=%b req=%b ref=%b required %b/%b/0",
                   k, video_next, dram_req, dram_refresh, exp_vid, exp_vid);
        end
      end
      if (cyc == 32) vfetch_win = 1'b0;
      step();
    end
    // Full density holds refresh off; once the window falls the pending
    // refresh takes the very next slot.
    do_reset();
    vfetch_win = 1'b1;
    vdens      = 2'b11;
    while (cyc < 40) begin
      p = cyc % 4;
      k = cyc / 4 - 1;
      exp_vid = (k < 6);
      exp_ref = (k == 6) || (k == 8);
      if (cyc >= 4 && p == 0) begin
        checks++;
        if (video_next_8 !== exp_vid || dram_req_8 !== exp_vid || dram_refresh_8 !== exp_ref) begin
          errors++;
          $display("FAIL window_fall_refresh slot%0d: vnext=%b req=%b ref=%b required %b/%b/%b",
                   k, video_next_8, dram_req_8, dram_refresh_8, exp_vid, exp_vid, exp_ref);
        end
      end
      if (cyc == 24) vfetch_win = 1'b0;
      step();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_slot();
    do_reset();
    cpu_req  = 1'b1;
    cpu_rnw  = 1'b1;
    cpu_addr = 21'h01234;
    while (cyc < 4) step();
    checks++;
    if (cpu_next !== 1'b1 || dram_req !== 1'b1 || dram_addr !== 21'h01234) begin
      errors++;
      $display("FAIL mid_reset_grant: cnext=%b req=%b addr=%h required 1/1/01234",
               cpu_next, dram_req, dram_addr);
    end
    step();
    rst = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL mid_reset_abort clk%0d: outputs=%h required 0", cyc, all_out);
      end
    end
    rst = 1'b0;
    cyc = 0;
    while (cyc < 4) begin
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL mid_reset_restart clk%0d: outputs=%h required 0", cyc, all_out);
      end
      step();
    end
    checks++;
    if (cpu_next !== 1'b1 || dram_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_regrant: cnext=%b req=%b required 1/1", cpu_next, dram_req);
    end
    repeat (3) step();
    checks++;
    if (cpu_strobe !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_strobe: cstb=%b required 1", cpu_strobe);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    test_reset();
    test_full_video();
    test_density_q_cpu();
    test_refresh_vs_cpu();
    test_window_edge();
    test_reset_mid_slot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(36 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
